// File: rtl/demux_pkg.sv
// Shared constants and helpers for the demux_route datapath demultiplexer.
// Used by demux_fifo and demux_route.
package demux_pkg;

    localparam int WIDTH_DEFAULT = 32;
    localparam int DEPTH_DEFAULT = 2;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/demux_fifo.sv
// Small synchronous FIFO holding the words queued for one demux output port.
// Head data reads as zero whenever the FIFO is empty.
module demux_fifo
    import demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // A full FIFO refuses a write even when it is popped in the same cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = empty ? '0 : mem[rd_ptr];

    // Storage is written only on an accepted push; no reset is needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/demux_route.sv
// Registered 1-to-2 demultiplexer with a private FIFO per output port.
// Define DEMUX_COUNT_EN to add the per-port delivered-word counters cnt0/cnt1.
module demux_route
    import demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
`ifdef DEMUX_COUNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready
`ifdef DEMUX_COUNT_EN
    ,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
`endif
);

    logic full0;
    logic full1;
    logic empty0;
    logic empty1;
    logic push0;
    logic push1;
    logic pop0;
    logic pop1;
    logic accept;

    // Readiness looks only at the selected FIFO's registered fill level.
    assign in_ready   = (in_sel == PORT1) ? ~full1 : ~full0;
    assign accept     = in_valid & in_ready;
    assign push0      = accept & (in_sel == PORT0);
    assign push1      = accept & (in_sel == PORT1);
    assign out0_valid = ~empty0;
    assign out1_valid = ~empty1;
    assign pop0       = out0_valid & out0_ready;
    assign pop1       = out1_valid & out1_ready;

    demux_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_fifo0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push0),
        .push_data(in_data),
        .pop      (pop0),
        .full     (full0),
        .empty    (empty0),
        .head     (out0_data)
    );

    demux_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_fifo1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push1),
        .push_data(in_data),
        .pop      (pop1),
        .full     (full1),
        .empty    (empty1),
        .head     (out1_data)
    );

`ifdef DEMUX_COUNT_EN
    // Count completed output handshakes per port, wrapping at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (pop0) begin
                cnt0 <= cnt0 + CNT_W'(1);
            end
            if (pop1) begin
                cnt1 <= cnt1 + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_demux_route.sv
// Self-checking bench for demux_route: directed vector table, hand sequences
// and a randomized run compared against a queue-based reference model.
module tb_demux_route;

    localparam int DEPTH = 2;
    localparam int CNT_W = 16;

    typedef struct {
        logic [31:0] d;
        logic        s;
        logic        v;
        logic        r0;
        logic        r1;
        logic        e_rdy;
        logic        e_v0;
        logic [31:0] e_d0;
        logic        e_v1;
        logic [31:0] e_d1;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_data;
    logic        in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out0_data;
    logic        out0_valid;
    logic        out0_ready;
    logic [31:0] out1_data;
    logic        out1_valid;
    logic        out1_ready;
`ifdef DEMUX_COUNT_EN
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;
`endif

    int checks = 0;
    int failures = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] rx0[$];
    logic [31:0] rx1[$];
    logic [CNT_W-1:0] m_cnt0 = '0;
    logic [CNT_W-1:0] m_cnt1 = '0;

    vec_t tbl[17];

    always #5 clk = ~clk;

    demux_route dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out0_data (out0_data),
        .out0_valid(out0_valid),
        .out0_ready(out0_ready),
        .out1_data (out1_data),
        .out1_valid(out1_valid),
        .out1_ready(out1_ready)
`ifdef DEMUX_COUNT_EN
        ,
        .cnt0      (cnt0),
        .cnt1      (cnt1)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mkv(input logic [31:0] d, input logic s,
                                 input logic v, input logic r0, input logic r1,
                                 input logic e_rdy, input logic e_v0,
                                 input logic [31:0] e_d0, input logic e_v1,
                                 input logic [31:0] e_d1);
        vec_t t;
        t.d = d; t.s = s; t.v = v; t.r0 = r0; t.r1 = r1;
        t.e_rdy = e_rdy; t.e_v0 = e_v0; t.e_d0 = e_d0;
        t.e_v1 = e_v1; t.e_d1 = e_d1;
        return t;
    endfunction

    task automatic model_check();
        logic exp_rdy;
        exp_rdy = in_sel ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
        chk("model_in_ready", in_ready, exp_rdy);
        chk("model_out0_valid", out0_valid, q0.size() > 0);
        chk("model_out0_data", out0_data, (q0.size() > 0) ? q0[0] : 32'h0);
        chk("model_out1_valid", out1_valid, q1.size() > 0);
        chk("model_out1_data", out1_data, (q1.size() > 0) ? q1[0] : 32'h0);
`ifdef DEMUX_COUNT_EN
        chk("model_cnt0", cnt0, m_cnt0);
        chk("model_cnt1", cnt1, m_cnt1);
`endif
    endtask

    // One clock: drive, check at the falling edge, then advance the model.
    task automatic step(input logic [31:0] d, input logic s, input logic v,
                        input logic r0, input logic r1, input bit use_t,
                        input vec_t t, output logic acc);
        logic p0;
        logic p1;
        in_data = d;
        in_sel = s;
        in_valid = v;
        out0_ready = r0;
        out1_ready = r1;
        @(negedge clk);
        if (use_t) begin
            chk("tbl_in_ready", in_ready, t.e_rdy);
            chk("tbl_out0_valid", out0_valid, t.e_v0);
            chk("tbl_out0_data", out0_data, t.e_d0);
            chk("tbl_out1_valid", out1_valid, t.e_v1);
            chk("tbl_out1_data", out1_data, t.e_d1);
        end
        model_check();
        acc = v && (s ? (q1.size() < DEPTH) : (q0.size() < DEPTH));
        p0 = r0 && (q0.size() > 0);
        p1 = r1 && (q1.size() > 0);
        if (p0) rx0.push_back(out0_data);
        if (p1) rx1.push_back(out1_data);
        @(posedge clk);
        if (p0) begin
            void'(q0.pop_front());
            m_cnt0 = m_cnt0 + 1'b1;
        end
        if (p1) begin
            void'(q1.pop_front());
            m_cnt1 = m_cnt1 + 1'b1;
        end
        if (acc) begin
            if (s) q1.push_back(d);
            else q0.push_back(d);
        end
        #1;
    endtask

    task automatic model_clear();
        q0.delete();
        q1.delete();
        rx0.delete();
        rx1.delete();
        m_cnt0 = '0;
        m_cnt1 = '0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        vec_t none;
        logic acc;
        logic [31:0] d;
        logic s;
        logic v;
        bit hold;
        int idx;
        int cyc;

        none = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[0]  = mkv(32'hAAAAAAAA, 1, 1, 1, 1, 1, 0, 32'h0, 0, 32'h0);
        tbl[1]  = mkv(32'h0, 0, 0, 1, 1, 1, 0, 32'h0, 1, 32'hAAAAAAAA);
        tbl[2]  = mkv(32'h0, 0, 0, 1, 1, 1, 0, 32'h0, 0, 32'h0);
        tbl[3]  = mkv(32'h0, 0, 1, 0, 1, 1, 0, 32'h0, 0, 32'h0);
        tbl[4]  = mkv(32'h55555555, 0, 1, 0, 1, 1, 1, 32'h0, 0, 32'h0);
        tbl[5]  = mkv(32'hFFFFFFFF, 0, 1, 0, 1, 0, 1, 32'h0, 0, 32'h0);
        tbl[6]  = mkv(32'hA5A5A5A5, 1, 1, 0, 0, 1, 1, 32'h0, 0, 32'h0);
        tbl[7]  = mkv(32'hFFFFFFFF, 0, 1, 0, 1, 0, 1, 32'h0, 1, 32'hA5A5A5A5);
        tbl[8]  = mkv(32'hFFFFFFFF, 0, 1, 1, 1, 0, 1, 32'h0, 0, 32'h0);
        tbl[9]  = mkv(32'hFFFFFFFF, 0, 1, 1, 1, 1, 1, 32'h55555555, 0, 32'h0);
        tbl[10] = mkv(32'h0, 0, 0, 1, 1, 1, 1, 32'hFFFFFFFF, 0, 32'h0);
        tbl[11] = mkv(32'h0, 0, 0, 1, 1, 1, 0, 32'h0, 0, 32'h0);
        tbl[12] = mkv(32'h11111111, 1, 1, 1, 0, 1, 0, 32'h0, 0, 32'h0);
        tbl[13] = mkv(32'hDDDDDDDD, 1, 1, 1, 1, 1, 0, 32'h0, 1, 32'h11111111);
        tbl[14] = mkv(32'h0, 1, 0, 1, 0, 1, 0, 32'h0, 1, 32'hDDDDDDDD);
        tbl[15] = mkv(32'h0, 1, 0, 1, 1, 1, 0, 32'h0, 1, 32'hDDDDDDDD);
        tbl[16] = mkv(32'h0, 1, 0, 1, 1, 1, 0, 32'h0, 0, 32'h0);

        rst_n = 1'b0;
        in_data = '0;
        in_sel = 1'b0;
        in_valid = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out0_valid", out0_valid, 1'b0);
        chk("reset_out1_valid", out1_valid, 1'b0);
        chk("reset_out0_data", out0_data, 32'h0);
        chk("reset_out1_data", out1_data, 32'h0);
        chk("reset_in_ready", in_ready, 1'b1);
`ifdef DEMUX_COUNT_EN
        chk("reset_cnt0", cnt0, 16'h0);
        chk("reset_cnt1", cnt1, 16'h0);
`endif
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].d, tbl[i].s, tbl[i].v, tbl[i].r0, tbl[i].r1, 1'b1,
                 tbl[i], acc);
        end
`ifdef DEMUX_COUNT_EN
        chk("tbl_cnt0", cnt0, 16'd3);
        chk("tbl_cnt1", cnt1, 16'd4);
`endif

        step(32'hC0C00001, 0, 1, 0, 0, 1'b0, none, acc);
        step(32'hC1C10001, 1, 1, 0, 0, 1'b0, none, acc);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out0_valid", out0_valid, 1'b0);
        chk("async_out1_valid", out1_valid, 1'b0);
        chk("async_out0_data", out0_data, 32'h0);
        chk("async_out1_data", out1_data, 32'h0);
`ifdef DEMUX_COUNT_EN
        chk("async_cnt0", cnt0, 16'h0);
        chk("async_cnt1", cnt1, 16'h0);
`endif
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(32'h12345678, 0, 1, 0, 0, 1'b1,
             mkv(0, 0, 0, 0, 0, 1, 0, 32'h0, 0, 32'h0), acc);
        step(32'h0, 0, 0, 1, 1, 1'b1,
             mkv(0, 0, 0, 0, 0, 1, 1, 32'h12345678, 0, 32'h0), acc);
        step(32'h0, 0, 0, 1, 1, 1'b1,
             mkv(0, 0, 0, 0, 0, 1, 0, 32'h0, 0, 32'h0), acc);

        do_reset();
        idx = 0;
        cyc = 0;
        while (idx < 8 && cyc < 200) begin
            step(32'(idx + 1), idx[0], 1'b1, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'b0, none, acc);
            if (acc) idx++;
            cyc++;
        end
        chk("wrap_accepted", 32'(idx), 32'd8);
        repeat (6) step(32'h0, 0, 0, 1, 1, 1'b0, none, acc);
        chk("wrap_rx0_size", 32'(rx0.size()), 32'd4);
        chk("wrap_rx1_size", 32'(rx1.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("wrap_rx0_word", (i < rx0.size()) ? rx0[i] : 32'hDEAD0000,
                32'(2 * i + 1));
            chk("wrap_rx1_word", (i < rx1.size()) ? rx1[i] : 32'hDEAD0000,
                32'(2 * i + 2));
        end
`ifdef DEMUX_COUNT_EN
        chk("wrap_cnt0", cnt0, 16'd4);
        chk("wrap_cnt1", cnt1, 16'd4);
`endif

        hold = 1'b0;
        d = '0;
        s = 1'b0;
        v = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!hold) begin
                d = $urandom;
                s = 1'($urandom_range(0, 1));
                v = ($urandom_range(0, 3) != 0);
            end
            step(d, s, v, ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) != 0), 1'b0, none, acc);
            hold = v && !acc;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux_route.md
Name: demux_route

Overview:
- Registered 1-to-2 demultiplexer for 32-bit datapath words; the inverse of the datapath 2:1 mux.
- Accepts one word per cycle on a valid/ready input and steers it by `sel` to output port 0 or 1.
- Each output has its own small FIFO, so a stalled consumer on one port does not block traffic to the other port.
- Sits between a producer stage and two independent consumer stages in the lab pipeline.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 2, entries per output FIFO; power of two, minimum 2.
- CNT_W, 16, width of the per-port word counters (optional feature only).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  WIDTH  word to route.
- in_sel  in  1  0 routes to port 0, 1 routes to port 1.
- in_valid  in  1  in_data and in_sel are valid.
- in_ready  out  1  selected port can accept the word this cycle.
- out0_data  out  WIDTH  head word of FIFO 0.
- out0_valid  out  1  FIFO 0 is non-empty.
- out0_ready  in  1  consumer 0 takes the head word.
- out1_data, out1_valid, out1_ready: same as port 0, for port 1.
- cnt0, cnt1  out  CNT_W  words delivered per port (present only with DEMUX_COUNT_EN).

Behaviour:
- Reset is asserted asynchronously while rst_n=0. During reset:
  - both FIFOs are emptied and their pointers are zeroed;
  - out0_valid=0, out1_valid=0;
  - out*_data=0 (the storage array may stay uninitialised, but the output data mux must drive 0 while the port is empty);
  - cnt0=cnt1=0.
- Reset asserted mid-transfer discards all queued words. No partial handshake survives reset.
- Readiness: in_ready = in_sel ? !full1 : !full0.
  - Combinational from in_sel and the registered FIFO counts only; it never depends on out*_ready.
  - A full FIFO does not accept a write in the same cycle it is popped (no bypass).
- Accept: in_valid & in_ready at a rising edge pushes in_data into FIFO[in_sel].
  - in_sel is sampled only at the accept edge.
  - in_valid=0 means in_sel is don't-care.
- Latency: a word accepted at edge N appears on outS_data with outS_valid=1 after edge N, i.e. one cycle. There is no combinational input-to-output path.
- Pop: outS_valid & outS_ready at an edge removes the head word. out*_ready while the port is empty is ignored.
- Simultaneous push and pop on the same non-full FIFO: count is unchanged and both operations take effect.
- Push and pop on different ports in the same cycle are fully independent.
- Ordering: FIFO order is preserved per port. No ordering relation exists between the two ports.
- Pointers: wrap modulo DEPTH. count ranges 0..DEPTH; full means count==DEPTH; empty means count==0.
- Producer contract (not checked in RTL): the producer holds in_data and in_sel stable while in_valid=1 and in_ready=0.

Optional Feature:
- Macro: DEMUX_COUNT_EN.
- Defined:
  - cnt0 and cnt1 ports exist.
  - Each increments by 1 per completed output handshake on its port.
  - Each wraps modulo 2^CNT_W.
  - Both reset to 0.
- Undefined: counter ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package demux_pkg holds:
  - WIDTH_DEFAULT=32 and DEPTH_DEFAULT=2;
  - port index constants PORT0=0 and PORT1=1;
  - a helper function clog2 for pointer widths.
- One sub-module: demux_fifo (WIDTH, DEPTH), a synchronous FIFO with push, pop, full, empty and head data.
  - It uses the same clk and rst_n.
  - demux_route instantiates it twice and adds the steering, readiness and counter logic.

Test Plan:
- Basic steer:
  - in_data=0xAAAAAAAA, sel=1, valid one cycle, both readies=1 → next cycle out1_valid=1, out1_data=0xAAAAAAAA.
  - out0_valid stays 0 throughout.
  - cnt1=1 (DEMUX_COUNT_EN).
- Backpressure:
  - out0_ready=0; push 0x00000000, 0x55555555, 0xFFFFFFFF on sel=0 → in_ready falls to 0 after two accepts.
  - Third word held; once out0_ready=1, words emerge in order 0x00000000, 0x55555555, 0xFFFFFFFF.
- Port isolation:
  - With FIFO 0 full and out0_ready=0, push 0xA5A5A5A5 with sel=1 → in_ready=1, word delivered on port 1 one cycle later.
  - FIFO 0 contents unchanged.
- Simultaneous push/pop:
  - FIFO 1 holds 1 entry; same edge pushes 0xDDDDDDDD (sel=1) and pops with out1_ready=1 → count stays 1, head becomes 0xDDDDDDDD.
- Wrap-around:
  - Stream 8 words 0x1..0x8 alternating sel with random ready stalls → each port receives its subsequence in order.
  - Pointers wrap without loss; cnt0=cnt1=4.
- Async reset mid-operation:
  - Drop rst_n between clock edges with both FIFOs holding data → out*_valid=0 immediately, cnt*=0.
  - After release, the first accepted word emerges one cycle later with no stale data.
